// File: rtl/binary_to_bcd_converter.sv
// binary_to_bcd_converter
//   Sequential two's-complement to sign + packed-BCD converter built on a
//   shift-add-3 (double-dabble) datapath. One conversion takes DW shift
//   cycles. Results feed the per-digit seven-segment decoders directly.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   start         launch a conversion (sampled only in IDLE)
//   binary_number DW-bit signed operand, sampled with start
//   busy          high while shifting
//   done          one-cycle pulse when sign/bcd_digits/error update
//   sign          operand was negative
//   bcd_digits    packed digits, [3:0] = units, [7:4] = tens, ...
//   error         magnitude exceeds 10^DIGITS-1 (bcd_digits forced to 0)
//
// The overflow compare is done on a 32-bit extension of the magnitude, so
// DW must not exceed 32 and DIGITS must not exceed 9.

// Per-digit correction: a nibble >= 5 gets +3 so that the following left
// shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module binary_to_bcd_converter #(
  parameter int DW     = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DW-1:0]         binary_number,
  output logic                  busy,
  output logic                  done,
  output logic                  sign,
  output logic [4*DIGITS-1:0]   bcd_digits,
  output logic                  error
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST    = CW'(DW - 1);
  localparam logic [31:0]   MAX_VAL = 32'(10 ** DIGITS - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   mag_sr;
  logic [BW-1:0]   bcd_sr;
  logic            sign_cap;
  logic            ovf_cap;

  logic [DW-1:0]   mag_in;
  logic            ovf_in;
  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_shift;
  logic            last_shift;

  // -2^(DW-1) negates to itself, which read as unsigned is exactly 2^(DW-1).
  assign mag_in = binary_number[DW-1] ? (~binary_number + DW'(1)) : binary_number;
  assign ovf_in = 32'(mag_in) > MAX_VAL;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    bcd_add3 u_add3 (
      .din  (bcd_sr[4*d +: 4]),
      .dout (bcd_adj[4*d +: 4])
    );
  end

  assign bcd_shift  = {bcd_adj[BW-2:0], mag_sr[DW-1]};
  assign last_shift = (state == CONV) && (cnt == LAST);
  assign busy       = (state == CONV);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start)      state_nxt = CONV;
      CONV: if (last_shift) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      mag_sr     <= '0;
      bcd_sr     <= '0;
      sign_cap   <= 1'b0;
      ovf_cap    <= 1'b0;
      done       <= 1'b0;
      sign       <= 1'b0;
      bcd_digits <= '0;
      error      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          sign_cap <= binary_number[DW-1];
          ovf_cap  <= ovf_in;
          mag_sr   <= mag_in;
          bcd_sr   <= '0;
          cnt      <= '0;
        end
      end else begin
        bcd_sr <= bcd_shift;
        mag_sr <= mag_sr << 1;
        cnt    <= cnt + CW'(1);
        if (last_shift) begin
          // Load from the post-shift value so the last bit is included.
          sign       <= sign_cap;
          error      <= ovf_cap;
          bcd_digits <= ovf_cap ? '0 : bcd_shift;
          done       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
module tb_binary_to_bcd_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // DIGITS=3 instance
  logic        start1 = 1'b0;
  logic [7:0]  num1   = '0;
  logic        busy1, done1, sign1, error1;
  logic [11:0] bcd1;

  // DIGITS=2 instance for overflow boundaries
  logic        start2 = 1'b0;
  logic [7:0]  num2   = '0;
  logic        busy2, done2, sign2, error2;
  logic [7:0]  bcd2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  binary_to_bcd_converter #(.DW(8), .DIGITS(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .binary_number(num1),
    .busy(busy1), .done(done1), .sign(sign1), .bcd_digits(bcd1), .error(error1)
  );

  binary_to_bcd_converter #(.DW(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .binary_number(num2),
    .busy(busy2), .done(done2), .sign(sign2), .bcd_digits(bcd2), .error(error2)
  );

  // busy and done must never overlap
  always @(negedge clk) begin
    checks++;
    if ((busy1 && done1) || (busy2 && done2)) begin
      failures++;
      $display("FAIL busy_done_overlap: dut1 busy=%0b done=%0b dut2 busy=%0b done=%0b, required not both high",
               busy1, done1, busy2, done2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic launch(input bit d2, input logic [7:0] n);
    if (d2) begin start2 = 1'b1; num2 = n; end
    else    begin start1 = 1'b1; num1 = n; end
    tick();
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Edges from the start edge until done is seen; -1 on timeout.
  task automatic wait_done(input bit d2, output int edges);
    edges = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (d2 ? done2 : done1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b1; num1 = 8'h7F; start2 = 1'b1; num2 = 8'h7F;
    tick(); tick();
    checks++;
    if ({busy1, done1, sign1, bcd1, error1} !== 16'h0) begin
      failures++;
      $display("FAIL reset_dut1: got busy=%0b done=%0b sign=%0b bcd=%h err=%0b, required all 0",
               busy1, done1, sign1, bcd1, error1);
    end
    checks++;
    if ({busy2, done2, sign2, bcd2, error2} !== 12'h0) begin
      failures++;
      $display("FAIL reset_dut2: got busy=%0b done=%0b sign=%0b bcd=%h err=%0b, required all 0",
               busy2, done2, sign2, bcd2, error2);
    end
    start1 = 1'b0; start2 = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_busy: got %0b, required 0", busy1);
    end
  endtask

  task automatic test_extremes();
    logic [7:0]  vin [4] = '{8'h7F, 8'h80, 8'hFF, 8'h00};
    logic        vsg [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [11:0] vbc [4] = '{12'h127, 12'h128, 12'h001, 12'h000};
    int e;
    for (int i = 0; i < 4; i++) begin
      launch(1'b0, vin[i]);
      checks++;
      if (busy1 !== 1'b1) begin
        failures++;
        $display("FAIL extreme_busy[%h]: got %0b, required 1", vin[i], busy1);
      end
      wait_done(1'b0, e);
      checks++;
      if (e !== 8) begin
        failures++;
        $display("FAIL extreme_latency[%h]: got %0d edges, required 8", vin[i], e);
      end
      checks++;
      if (sign1 !== vsg[i] || bcd1 !== vbc[i] || error1 !== 1'b0) begin
        failures++;
        $display("FAIL extreme_result[%h]: got sign=%0b bcd=%h err=%0b, required sign=%0b bcd=%h err=0",
                 vin[i], sign1, bcd1, error1, vsg[i], vbc[i]);
      end
      tick();
      checks++;
      if (done1 !== 1'b0) begin
        failures++;
        $display("FAIL extreme_done_pulse[%h]: got done=%0b one cycle later, required 0", vin[i], done1);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vin [3] = '{8'h63, 8'h64, 8'h9C};
    logic       vsg [3] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] vbc [3] = '{8'h99, 8'h00, 8'h00};
    logic       ver [3] = '{1'b0, 1'b1, 1'b1};
    int e;
    for (int i = 0; i < 3; i++) begin
      launch(1'b1, vin[i]);
      wait_done(1'b1, e);
      checks++;
      if (e !== 8) begin
        failures++;
        $display("FAIL ovf_latency[%h]: got %0d edges, required 8", vin[i], e);
      end
      checks++;
      if (sign2 !== vsg[i] || bcd2 !== vbc[i] || error2 !== ver[i]) begin
        failures++;
        $display("FAIL ovf_result[%h]: got sign=%0b bcd=%h err=%0b, required sign=%0b bcd=%h err=%0b",
                 vin[i], sign2, bcd2, error2, vsg[i], vbc[i], ver[i]);
      end
      tick();
    end
  endtask

  task automatic test_start_ignored();
    int          ndone = 0;
    int          first = -1;
    logic [11:0] res   = '0;
    launch(1'b0, 8'h2A);
    for (int i = 1; i <= 20; i++) begin
      start1 = (i == 3 || i == 5);
      num1   = start1 ? 8'h11 : 8'h2A;
      tick();
      if (done1) begin
        ndone++;
        if (first < 0) begin first = i; res = bcd1; end
      end
    end
    start1 = 1'b0;
    checks++;
    if (ndone !== 1 || first !== 8) begin
      failures++;
      $display("FAIL ignore_start_done: got %0d pulses first at edge %0d, required 1 at edge 8", ndone, first);
    end
    checks++;
    if (res !== 12'h042) begin
      failures++;
      $display("FAIL ignore_start_result: got bcd=%h, required 042", res);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    launch(1'b0, 8'h2A);
    wait_done(1'b0, e);
    checks++;
    if (e !== 8 || bcd1 !== 12'h042 || sign1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first: got edges=%0d bcd=%h sign=%0b, required 8/042/0", e, bcd1, sign1);
    end
    launch(1'b0, 8'hD6);
    checks++;
    if (busy1 !== 1'b1 || sign1 !== 1'b0 || bcd1 !== 12'h042) begin
      failures++;
      $display("FAIL b2b_accept_hold: got busy=%0b sign=%0b bcd=%h, required busy=1 held 0/042",
               busy1, sign1, bcd1);
    end
    wait_done(1'b0, e);
    checks++;
    if (e < 0 || e + 1 !== 9) begin
      failures++;
      $display("FAIL b2b_spacing: got %0d cycles between dones, required 9", e + 1);
    end
    checks++;
    if (sign1 !== 1'b1 || bcd1 !== 12'h042 || error1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second: got sign=%0b bcd=%h err=%0b, required 1/042/0", sign1, bcd1, error1);
    end
    tick();
  endtask

  task automatic test_hold();
    int e;
    launch(1'b0, 8'h7F);
    wait_done(1'b0, e);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0 || sign1 !== 1'b0 || bcd1 !== 12'h127 || error1 !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d]: got done=%0b busy=%0b sign=%0b bcd=%h err=%0b, required 0/0/0/127/0",
                 i, done1, busy1, sign1, bcd1, error1);
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int e;
    launch(1'b0, 8'h55);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy1, done1, sign1, bcd1, error1} !== 16'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got busy=%0b done=%0b sign=%0b bcd=%h err=%0b, required all 0",
               busy1, done1, sign1, bcd1, error1);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done1) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_done: got %0d pulses, required 0", ndone);
    end
    launch(1'b0, 8'hAB);
    wait_done(1'b0, e);
    checks++;
    if (e !== 8 || sign1 !== 1'b1 || bcd1 !== 12'h085 || error1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_next: got edges=%0d sign=%0b bcd=%h err=%0b, required 8/1/085/0",
               e, sign1, bcd1, error1);
    end
  endtask

  initial begin
    test_reset();
    test_extremes();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
